// File: rtl/arith_pkg.sv
// Shared arithmetic types: serial subtractor FSM states and counter sizing helper.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // Bit counter must hold WIDTH-1; a 1-bit counter still exists when WIDTH=1.
  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Operand-in / result-out handshake bundle for the bit-serial subtractor.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, busy
  );
endinterface

// File: rtl/full_sub_cell.sv
// 1-bit full subtractor: d = a - b - bin, bout set when that goes negative.
// Latency: combinational. Backpressure: none.
// Shared by every bit position of the serial engine.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & (b ^ bin)) | (b & bin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin, LSB first, through one full_sub_cell.
// Latency: WIDTH+1 cycles accept-to-result; one op per WIDTH+1 cycles back-to-back.
// Backpressure: result held in DONE until out_ready; in_ready low during SHIFT.
module serial_sub_ctrl
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_sub_ctrl_if.slave  io
);

  localparam int CW = cnt_width(WIDTH);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, diff_sh, diff_nx;
  logic [CW-1:0]    cnt;
  logic             brw, d, nb;
  logic             load, last;

  full_sub_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .d    (d),
    .bout (nb)
  );

  assign last         = (cnt == CW'(WIDTH - 1));
  assign io.in_ready  = (state_q == IDLE) | ((state_q == DONE) & io.out_ready);
  assign load         = io.in_valid & io.in_ready;
  assign io.out_valid = (state_q == DONE);
  assign io.busy      = (state_q == SHIFT);
  assign io.diff      = diff_sh;
  assign io.bout      = brw;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.in_valid) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    if (io.out_ready) state_d = io.in_valid ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // New bit enters at the MSB so the full result is aligned after WIDTH shifts.
  always_comb begin
    diff_nx             = diff_sh >> 1;
    diff_nx[WIDTH-1]    = d;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      brw     <= 1'b0;
      cnt     <= '0;
    end else if (load) begin
      a_sh    <= io.a;
      b_sh    <= io.b;
      brw     <= io.bin;
      cnt     <= '0;
    end else if (state_q == SHIFT) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      diff_sh <= diff_nx;
      brw     <= nb;
      cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench: WIDTH=8, 1 and 64 instances against an arithmetic reference model.
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Common driver, routed to the selected instance: 0 -> W8, 1 -> W1, 2 -> W64.
  int          sel = 0;
  logic        drv_valid = 1'b0;
  logic [63:0] drv_a = '0;
  logic [63:0] drv_b = '0;
  logic        drv_bin = 1'b0;
  logic        drv_out_ready = 1'b1;

  logic        obs_in_ready, obs_out_valid, obs_bout, obs_busy;
  logic [63:0] obs_diff;

  serial_sub_ctrl_if #(.WIDTH(8))  if8  ();
  serial_sub_ctrl_if #(.WIDTH(1))  if1  ();
  serial_sub_ctrl_if #(.WIDTH(64)) if64 ();

  serial_sub_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .io(if8));
  serial_sub_ctrl #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .io(if1));
  serial_sub_ctrl #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .io(if64));

  assign if8.in_valid   = drv_valid && (sel == 0);
  assign if8.a          = drv_a[7:0];
  assign if8.b          = drv_b[7:0];
  assign if8.bin        = drv_bin;
  assign if8.out_ready  = drv_out_ready;
  assign if1.in_valid   = drv_valid && (sel == 1);
  assign if1.a          = drv_a[0:0];
  assign if1.b          = drv_b[0:0];
  assign if1.bin        = drv_bin;
  assign if1.out_ready  = drv_out_ready;
  assign if64.in_valid  = drv_valid && (sel == 2);
  assign if64.a         = drv_a;
  assign if64.b         = drv_b;
  assign if64.bin       = drv_bin;
  assign if64.out_ready = drv_out_ready;

  always_comb begin
    obs_in_ready  = if8.in_ready;
    obs_out_valid = if8.out_valid;
    obs_diff      = 64'(if8.diff);
    obs_bout      = if8.bout;
    obs_busy      = if8.busy;
    if (sel == 1) begin
      obs_in_ready  = if1.in_ready;
      obs_out_valid = if1.out_valid;
      obs_diff      = 64'(if1.diff);
      obs_bout      = if1.bout;
      obs_busy      = if1.busy;
    end else if (sel == 2) begin
      obs_in_ready  = if64.in_ready;
      obs_out_valid = if64.out_valid;
      obs_diff      = if64.diff;
      obs_bout      = if64.bout;
      obs_busy      = if64.busy;
    end
  end

  // Reference: exact unsigned subtraction one bit wider; the extra bit is the borrow.
  function automatic logic [64:0] ref_sub(input logic [63:0] a, input logic [63:0] b,
                                          input logic bin, input int w);
    logic [63:0] m;
    logic [64:0] r;
    m = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    r = {1'b0, a & m} - {1'b0, b & m} - {64'd0, bin};
    return {r[64], r[63:0] & m};
  endfunction

  // Drives one operation from IDLE and collects its result; caller is at a negedge.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic bin,
                       output logic [63:0] d, output logic bo, output int lat, output bit to);
    drv_a = a; drv_b = b; drv_bin = bin; drv_valid = 1'b1; drv_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    drv_valid = 1'b0;
    drv_a = {$urandom, $urandom}; drv_b = {$urandom, $urandom}; drv_bin = 1'($urandom_range(0, 1));
    lat = 0;
    while (!obs_out_valid && lat < 200) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    to = !obs_out_valid;
    d  = obs_diff;
    bo = obs_bout;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; drv_valid = 1'b0; drv_out_ready = 1'b1; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", obs_in_ready); end
    n_tests++; if (obs_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", obs_out_valid); end
    n_tests++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", obs_busy); end
    n_tests++; if (obs_diff !== 64'd0 || obs_bout !== 1'b0) begin n_fail++; $display("FAIL reset_result: got %h/%b want 0/0", obs_diff, obs_bout); end
    n_tests++; if (if64.diff !== 64'd0 || if1.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_other: got %h/%b want 0/0", if64.diff, if1.out_valid); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_directed();
    logic [63:0] ta [6] = '{64'h5A, 64'h00, 64'hFF, 64'hFF, 64'h00, 64'h80};
    logic [63:0] tb_ [6] = '{64'h3C, 64'h01, 64'hFF, 64'h00, 64'h00, 64'h7F};
    logic        tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [63:0] d; logic bo; int lat; bit to; logic [64:0] e;
    sel = 0;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb_[i], tc[i], d, bo, lat, to);
      e = ref_sub(ta[i], tb_[i], tc[i], 8);
      n_tests++; if (to) begin n_fail++; $display("FAIL dir_timeout[%0d]: out_valid never rose", i); end
      n_tests++; if (d !== e[63:0] || bo !== e[64]) begin n_fail++; $display("FAIL dir_result[%0d]: got %h/%b want %h/%b", i, d, bo, e[63:0], e[64]); end
      n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL dir_latency[%0d]: got %0d edges want 8", i, lat); end
    end
  endtask

  task automatic test_random8();
    logic [63:0] a, b, d; logic c, bo; int lat; bit to; logic [64:0] e;
    sel = 0;
    for (int i = 0; i < 30; i++) begin
      a = 64'($urandom_range(0, 255)); b = 64'($urandom_range(0, 255)); c = 1'($urandom_range(0, 1));
      do_op(a, b, c, d, bo, lat, to);
      e = ref_sub(a, b, c, 8);
      n_tests++; if (to || d !== e[63:0] || bo !== e[64] || lat !== 8) begin
        n_fail++; $display("FAIL rand8[%0d]: got %h/%b lat %0d want %h/%b lat 8", i, d, bo, lat, e[63:0], e[64]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat = 0;
    sel = 0;
    drv_out_ready = 1'b0;
    drv_a = 64'h10; drv_b = 64'h01; drv_bin = 1'b0; drv_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    // Keep offering different operands; they must be ignored while busy or held.
    drv_a = 64'hAA; drv_b = 64'h55; drv_bin = 1'b1;
    n_tests++; if (obs_busy !== 1'b1 || obs_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_shift: busy/in_ready got %b/%b want 1/0", obs_busy, obs_in_ready); end
    while (!obs_out_valid && lat < 200) begin @(posedge clk); @(negedge clk); lat++; end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (obs_out_valid !== 1'b1 || obs_diff !== 64'h0F || obs_bout !== 1'b0 || obs_in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: vld/diff/bout/rdy got %b/%h/%b/%b want 1/0f/0/0", i, obs_out_valid, obs_diff, obs_bout, obs_in_ready);
      end
      @(posedge clk); @(negedge clk);
    end
    drv_valid = 1'b0;
    drv_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    n_tests++; if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_retire: vld/rdy got %b/%b want 0/1", obs_out_valid, obs_in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  sa[$], sb[$];
    logic        sc[$];
    logic [64:0] ex[$];
    logic [64:0] e;
    int got = 0, cyc = 0, last_cyc = 0, stray = 0;
    bit acc, ret;
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      sa.push_back(8'($urandom)); sb.push_back(8'($urandom)); sc.push_back(1'($urandom_range(0, 1)));
      ex.push_back(ref_sub(64'(sa[i]), 64'(sb[i]), sc[i], 8));
    end
    drv_out_ready = 1'b1;
    drv_a = 64'(sa[0]); drv_b = 64'(sb[0]); drv_bin = sc[0]; drv_valid = 1'b1;
    while (got < 4 && cyc < 200) begin
      acc = drv_valid && obs_in_ready;
      ret = obs_out_valid;
      if (ret) begin
        e = ex.pop_front();
        n_tests++; if (obs_diff !== e[63:0] || obs_bout !== e[64]) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b", got, obs_diff, obs_bout, e[63:0], e[64]); end
        if (got > 0) begin
          n_tests++; if (cyc - last_cyc !== 9) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want 9", got, cyc - last_cyc); end
        end
        last_cyc = cyc;
        got++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
      if (acc) begin
        void'(sa.pop_front()); void'(sb.pop_front()); void'(sc.pop_front());
        if (sa.size() == 0) drv_valid = 1'b0;
        else begin drv_a = 64'(sa[0]); drv_b = 64'(sb[0]); drv_bin = sc[0]; end
      end
    end
    drv_valid = 1'b0;
    n_tests++; if (got !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d results want 4", got); end
    repeat (20) begin
      if (obs_out_valid) stray++;
      @(posedge clk); @(negedge clk);
    end
    n_tests++; if (stray !== 0) begin n_fail++; $display("FAIL b2b_stray: got %0d extra out_valid cycles want 0", stray); end
  endtask

  task automatic test_reset_midop();
    logic [63:0] d; logic bo; int lat; bit to;
    int stray = 0;
    sel = 0;
    drv_a = 64'h33; drv_b = 64'h11; drv_bin = 1'b0; drv_valid = 1'b1; drv_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    drv_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_tests++;
    if (obs_out_valid !== 1'b0 || obs_diff !== 64'd0 || obs_busy !== 1'b0 || obs_bout !== 1'b0 || obs_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_state: vld/diff/busy/bout/rdy got %b/%h/%b/%b/%b want 0/0/0/0/1", obs_out_valid, obs_diff, obs_busy, obs_bout, obs_in_ready);
    end
    rst = 1'b0;
    repeat (12) begin
      if (obs_out_valid) stray++;
      @(posedge clk); @(negedge clk);
    end
    n_tests++; if (stray !== 0) begin n_fail++; $display("FAIL midrst_no_result: got %0d out_valid cycles want 0", stray); end
    do_op(64'h80, 64'h7F, 1'b0, d, bo, lat, to);
    n_tests++; if (to || d !== 64'h01 || bo !== 1'b0) begin n_fail++; $display("FAIL midrst_next: got %h/%b want 01/0", d, bo); end
  endtask

  task automatic test_width1();
    logic [63:0] d; logic bo; int lat; bit to; int r;
    logic [2:0] v;
    sel = 1;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      r = int'(v[2]) - int'(v[1]) - int'(v[0]);
      do_op(64'(v[2]), 64'(v[1]), v[0], d, bo, lat, to);
      n_tests++;
      if (to || d[0] !== r[0] || bo !== (r < 0) || lat !== 1) begin
        n_fail++; $display("FAIL w1[a=%b b=%b bin=%b]: got d=%b bout=%b lat=%0d want d=%b bout=%b lat=1", v[2], v[1], v[0], d[0], bo, lat, r[0], (r < 0));
      end
    end
  endtask

  task automatic test_width64();
    logic [63:0] a, b, d; logic c, bo; int lat; bit to; logic [64:0] e;
    sel = 2;
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0:       begin a = '0;          b = '1;          c = 1'b1; end
        1:       begin a = '1;          b = '1;          c = 1'b0; end
        2:       begin a = 64'd0;       b = 64'd0;       c = 1'b1; end
        default: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = 1'($urandom_range(0, 1)); end
      endcase
      do_op(a, b, c, d, bo, lat, to);
      e = ref_sub(a, b, c, 64);
      n_tests++;
      if (to || d !== e[63:0] || bo !== e[64] || lat !== 64) begin
        n_fail++; $display("FAIL w64[%0d]: got %h/%b lat %0d want %h/%b lat 64", i, d, bo, lat, e[63:0], e[64]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_random8();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_width1();
    test_width64();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller. It accepts two WIDTH-bit operands and a borrow-in through a valid/ready handshake, and sequences a single 1-bit full-subtractor cell LSB-first for WIDTH cycles. It then presents the WIDTH-bit difference and borrow-out through a second valid/ready handshake. This is the area-minimal subtract engine for the arithmetic datapath: one subtractor cell is time-shared across all bit positions.

## Interface
- WIDTH, default 8: operand and difference width; legal range 1 to 64.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands on a, b, bin are valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  diff and bout are valid.
- out_ready  in  1  consumer accepts the result.
- diff  out  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  out  1  1 when a < b + bin, treating all values as unsigned.
- busy  out  1  high in SHIFT.

## Operation
- States:
  - IDLE: waiting for operands.
  - SHIFT: serial computation in progress.
  - DONE: result held for the consumer.
- IDLE → SHIFT on in_valid & in_ready.
  - Latch a and b into shift registers.
  - Load the borrow register with bin.
  - Clear the bit counter.
- SHIFT, each cycle:
  - The cell computes d = a_sh[0] ^ b_sh[0] ^ brw and nb = (~a_sh[0] & (b_sh[0] ^ brw)) | (b_sh[0] & brw).
  - a_sh and b_sh shift right by one.
  - diff_sh shifts right with d entering the MSB.
  - brw <= nb.
  - The counter increments.
- SHIFT → DONE when the counter equals WIDTH-1, after that cycle's update.
  - diff = diff_sh.
  - bout = final brw.
- DONE → IDLE on out_ready, or DONE → SHIFT when out_ready & in_valid occur in the same cycle (back-to-back).
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is low throughout SHIFT, and in_valid is ignored there.
- out_valid = (state==DONE). diff and bout are stable while out_valid is high and out_ready is low.
- The counter is $clog2(WIDTH) bits, with a minimum of 1 bit. WIDTH=1 finishes SHIFT in a single cycle.
- No arithmetic is wider than 1 bit. The result is exact modulo 2^WIDTH, and bout is the true unsigned borrow.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready = 1 (combinational from state).
  - out_valid = 0, busy = 0.
  - diff = 0, bout = 0.
  - All internal shift, borrow and counter registers = 0.
- Latency: operands accepted at edge k; bits 0..WIDTH-1 processed on edges k+1..k+WIDTH; out_valid high from the cycle after edge k+WIDTH. Accept-to-result is WIDTH+1 cycles.
- Throughput: one operation per WIDTH+1 cycles with out_ready tied high, given back-to-back acceptance in DONE.
- Reset mid-operation (rst high in SHIFT or DONE):
  - Next cycle is IDLE with reset values.
  - No out_valid pulse for the aborted operation.
  - rst has priority over every handshake.
- Simultaneous out_ready & in_valid in DONE: the result retires and new operands are accepted on the same edge. out_valid drops for exactly WIDTH cycles.
- Operand inputs are sampled only on the accept edge. Later changes to a, b and bin have no effect.

## Structure
- Shared package arith_pkg:
  - sub_state_t enum {IDLE, SHIFT, DONE}.
  - Localparam helper for counter width: max(1, $clog2(WIDTH)).
- Sub-module full_sub_cell: purely combinational 1-bit full subtractor (a, b, bin → d, bout), instantiated once.
- serial_sub_ctrl holds the FSM, counter, shift registers, borrow register and handshake logic.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, bin=0, out_ready=1 → out_valid exactly 9 cycles after accept; diff=0x1E, bout=0.
- WIDTH=8, a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=1 → diff=0xFF, bout=1.
- Backpressure: result a=0x10, b=0x01; hold out_ready=0 for 5 cycles → out_valid, diff=0x0F and bout=0 stable all 5 cycles; in_ready=0 throughout.
- Back-to-back: in_valid held high with 4 queued operand sets, out_ready=1 → 4 results in order, one every 9 cycles, none dropped or duplicated.
- Reset mid-op: assert rst at the 3rd SHIFT cycle → next cycle IDLE, out_valid=0, diff=0, busy=0; the following operation (0x80-0x7F) gives diff=0x01, bout=0.
- WIDTH=1 exhaustive over all 8 (a,b,bin) combinations → matches the full-subtractor truth table; latency 2 cycles. WIDTH=64 random 1000 operations checked against a reference model.
